imm_extend_stage: RTL and testbench

Registered, parametrised immediate generator for the pipelined LEGv8 datapath, sitting between instruction fetch/decode and the register-read/execute stage. Extracts and extends the immediate field of a 32-bit instruction for five formats (I with optional LSL #12, D, B, CB, IW/MOVZ with 16-bit lane shift) to a configurable datapath width. Results are held in a 2-entry buffer with valid/ready handshakes on both sides, plus flush support for branch redirects.

---
 rtl/imm_extend_stage.sv | 117 +++++++++++
 tb/tb_imm_extend_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_stage.sv
// Immediate extraction/extension stage for the LEGv8 pipeline.
// Decodes I/D/B/CB/IW immediates into a 2-entry valid/ready buffer.
module imm_extend_stage #(
    parameter int DATA_W   = 64,
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       Instr,
    input  logic [2:0]        Ctrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] BusImm,
    output logic              BadCtrl
);

    logic        is_i;
    logic        is_d;
    logic        is_b;
    logic        is_cb;
    logic        is_iw;
    logic [63:0] ext;
    logic [63:0] iw_val;
    logic        bad;

    logic              unused_instr;
    logic [DATA_W-1:0] imm_q [2];
    logic              bad_q [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              accept;
    logic              pop;

    assign unused_instr = ^Instr[31:26];

    assign is_i  = (Ctrl == 3'b000);
    assign is_d  = (Ctrl == 3'b001);
    assign is_b  = (Ctrl == 3'b010);
    assign is_cb = (Ctrl == 3'b011);
    assign is_iw = (Ctrl == 3'b100);

    assign iw_val = {48'd0, Instr[20:5]} << {Instr[22:21], 4'd0};

    always_comb begin
        ext = '0;
        bad = 1'b0;
        unique case (1'b1)
            is_i: begin
                ext = {52'd0, Instr[21:10]};
                if (SHIFT_EN && Instr[22]) begin
                    ext = {40'd0, Instr[21:10], 12'd0};
                end
            end
            is_d: begin
                ext = {{55{Instr[20]}}, Instr[20:12]};
            end
            is_b: begin
                ext = {{36{Instr[25]}}, Instr[25:0], 2'b00};
            end
            is_cb: begin
                ext = {{43{Instr[23]}}, Instr[23:5], 2'b00};
            end
            is_iw: begin
                // Upper halfwords do not exist on a 32-bit datapath.
                if ((DATA_W == 32) && Instr[22]) begin
                    bad = 1'b1;
                end else begin
                    ext = iw_val;
                end
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    assign InReady  = (count != 2'd2);
    assign OutValid = (count != 2'd0);
    assign accept   = InValid && InReady;
    assign pop      = OutValid && OutReady;

    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !accept) begin
                count <= count - 2'd1;
            end
        end
    end

    // Storage needs no reset; the output mux hides it while empty.
    always_ff @(posedge CLK) begin
        if (accept && !Reset && !Flush) begin
            imm_q[wr_ptr] <= ext[DATA_W-1:0];
            bad_q[wr_ptr] <= bad;
        end
    end

    assign BusImm  = OutValid ? imm_q[rd_ptr] : '0;
    assign BadCtrl = OutValid ? bad_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: 64-bit/shift and 32-bit/no-shift
// instances share stimulus; a queue scoreboard tracks expected entries.
module tb_imm_extend_stage;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ctrl;
        logic [63:0] e64;
        logic        b64;
        logic [31:0] e32;
        logic        b32;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic        out_ready;

    logic        ir64;
    logic        ov64;
    logic [63:0] bus64;
    logic        bad64;
    logic        ir32;
    logic        ov32;
    logic [31:0] bus32;
    logic        bad32;

    int   npass;
    int   ntot;
    bit   mon_en;
    vec_t cur;
    vec_t q[$];
    vec_t tbl[11];
    vec_t va;
    vec_t vb;
    vec_t vc;

    imm_extend_stage #(.DATA_W(64), .SHIFT_EN(1'b1)) dut64 (
        .CLK(clk), .Reset(rst), .Flush(flush),
        .InValid(in_valid), .InReady(ir64),
        .Instr(instr), .Ctrl(ctrl),
        .OutValid(ov64), .OutReady(out_ready),
        .BusImm(bus64), .BadCtrl(bad64)
    );

    imm_extend_stage #(.DATA_W(32), .SHIFT_EN(1'b0)) dut32 (
        .CLK(clk), .Reset(rst), .Flush(flush),
        .InValid(in_valid), .InReady(ir32),
        .Instr(instr), .Ctrl(ctrl),
        .OutValid(ov32), .OutReady(out_ready),
        .BusImm(bus32), .BadCtrl(bad32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int  sz;
            bit  acc;
            bit  pp;
            sz  = q.size();
            acc = in_valid && (sz < 2);
            pp  = out_ready && (sz > 0);
            chk("outvalid64", {63'd0, ov64}, {63'd0, sz > 0});
            chk("outvalid32", {63'd0, ov32}, {63'd0, sz > 0});
            chk("inready64", {63'd0, ir64}, {63'd0, sz < 2});
            chk("inready32", {63'd0, ir32}, {63'd0, sz < 2});
            if (sz > 0) begin
                chk("busimm64", bus64, q[0].e64);
                chk("badctrl64", {63'd0, bad64}, {63'd0, q[0].b64});
                chk("busimm32", {32'd0, bus32}, {32'd0, q[0].e32});
                chk("badctrl32", {63'd0, bad32}, {63'd0, q[0].b32});
            end else begin
                chk("empty_bus64", bus64, 64'd0);
                chk("empty_bus32", {32'd0, bus32}, 64'd0);
                chk("empty_bad", {62'd0, bad64, bad32}, 64'd0);
            end
            if (rst || flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
        end
    end

    task automatic send(input vec_t v);
        bit ok;
        ok       = 1'b0;
        cur      = v;
        instr    = v.instr;
        ctrl     = v.ctrl;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = ir64;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        chk("send_accept", {63'd0, ok}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h17FF_FFFF, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
                    32'hFFFF_FFFC, 1'b0};
        tbl[1]  = '{32'h0010_0000, 3'b001, 64'hFFFF_FFFF_FFFF_FF00, 1'b0,
                    32'hFFFF_FF00, 1'b0};
        tbl[2]  = '{32'h006A_F000, 3'b000, 64'h0000_0000_00AB_C000, 1'b0,
                    32'h0000_0ABC, 1'b0};
        tbl[3]  = '{32'h0077_DDE0, 3'b100, 64'hBEEF_0000_0000_0000, 1'b0,
                    32'h0, 1'b1};
        tbl[4]  = '{32'hFFFF_FFFF, 3'b111, 64'h0, 1'b1, 32'h0, 1'b1};
        tbl[5]  = '{32'h0080_0000, 3'b011, 64'hFFFF_FFFF_FFF0_0000, 1'b0,
                    32'hFFF0_0000, 1'b0};
        tbl[6]  = '{32'h0022_4680, 3'b100, 64'h0000_0000_1234_0000, 1'b0,
                    32'h1234_0000, 1'b0};
        tbl[7]  = '{32'h003F_FC00, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0,
                    32'h0000_0FFF, 1'b0};
        tbl[8]  = '{32'h000F_F000, 3'b001, 64'h0000_0000_0000_00FF, 1'b0,
                    32'h0000_00FF, 1'b0};
        tbl[9]  = '{32'h1234_5678, 3'b101, 64'h0, 1'b1, 32'h0, 1'b1};
        tbl[10] = '{32'h0040_0020, 3'b100, 64'h0000_0001_0000_0000, 1'b0,
                    32'h0, 1'b1};
        va = '{32'h0000_0020, 3'b011, 64'h4, 1'b0, 32'h4, 1'b0};
        vb = '{32'h00FF_FFE0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
               32'hFFFF_FFFC, 1'b0};
        vc = '{32'h0024_68A0, 3'b011, 64'h0004_8D14, 1'b0,
               32'h0004_8D14, 1'b0};

        npass     = 0;
        ntot      = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        ctrl      = '0;
        out_ready = 1'b0;
        cur       = tbl[0];
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outvalid", {63'd0, ov64}, 64'd0);
        chk("reset_inready", {63'd0, ir64}, 64'd1);
        chk("reset_bus", bus64, 64'd0);
        chk("reset_bad", {63'd0, bad64}, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            out_ready = 1'b1;
            send(tbl[i]);
            @(posedge clk);
            #1;
        end

        out_ready = 1'b0;
        send(va);
        send(vb);
        cur      = vc;
        instr    = vc.instr;
        ctrl     = vc.ctrl;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_inready_low", {63'd0, ir64}, 64'd0);
            chk("bp_head_held", bus64, va.e64);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(vc);
        drain();

        out_ready = 1'b0;
        send(va);
        send(vb);
        cur      = vc;
        instr    = vc.instr;
        ctrl     = vc.ctrl;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_outvalid", {63'd0, ov64}, 64'd0);
        chk("flush2_inready", {63'd0, ir64}, 64'd1);
        @(posedge clk);
        #1;

        send(va);
        cur      = vc;
        instr    = vc.instr;
        ctrl     = vc.ctrl;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush1_outvalid", {63'd0, ov32}, 64'd0);
        chk("flush1_inready", {63'd0, ir32}, 64'd1);
        @(posedge clk);
        #1;

        send(tbl[3]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outvalid", {63'd0, ov64}, 64'd0);
        chk("rst_mid_bus", bus64, 64'd0);
        chk("rst_mid_bad", {62'd0, bad64, bad32}, 64'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        begin
            time t0;
            t0 = $time;
            for (int i = 0; i < 16; i++) send(tbl[i % 11]);
            chk("stream_cycles", 64'(($time - t0) / 10), 64'd16);
        end
        drain();
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
